// File: rtl/uarch_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// uarch_rst_seq_pkg
// Shared types and helpers for the fence.t micro-reset sequencer.
//   fence_t_state_e : sequencer FSM state encoding (3 bits)
//   fence_t_cfg_t   : groups the sequencer parameters
//   sel_width()     : width of a select that picks one of n sources (min 1)
//   cnt_width()     : width of a counter that must reach max_val (min 1)
// -----------------------------------------------------------------------------
package uarch_rst_seq_pkg;

   typedef enum logic [2:0] {
      FT_IDLE  = 3'd0,
      FT_FLUSH = 3'd1,
      FT_DRAIN = 3'd2,
      FT_PAD   = 3'd3,
      FT_RST   = 3'd4
   } fence_t_state_e;

   typedef struct packed {
      int unsigned num_flush;
      int unsigned drain_cycles;
      int unsigned rst_cycles;
      int unsigned init_hold;
      int unsigned num_pad_src;
      int unsigned pad_w;
      int unsigned vlen;
   } fence_t_cfg_t;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/uarch_rst_seq_if.sv
// -----------------------------------------------------------------------------
// uarch_rst_seq_if
// Flush-channel bundle between the fence.t sequencer and the caches/buffers.
//   flush_req : per-channel flush request (sequencer -> channel)
//   flush_ack : per-channel flush done pulse (channel -> sequencer)
//   busy      : per-channel outstanding-transaction flag (channel -> sequencer)
// master = sequencer side, slave = cache/buffer side.
// -----------------------------------------------------------------------------
interface uarch_rst_seq_if #(
   parameter int unsigned NUM_FLUSH = 2
);
   logic [NUM_FLUSH-1:0] flush_req;
   logic [NUM_FLUSH-1:0] flush_ack;
   logic [NUM_FLUSH-1:0] busy;

   modport master (
      output flush_req,
      input  flush_ack,
      input  busy
   );

   modport slave (
      input  flush_req,
      output flush_ack,
      output busy
   );
endinterface

// File: rtl/uarch_rst_seq_pad_timer.sv
// -----------------------------------------------------------------------------
// fence_t_pad_timer
// Free-running pad counter for fence.t timing padding.
//   clk_i, rst_ni  : clock, async active-low reset
//   pad_i          : reload value loaded on a rising edge of the selected event
//   pad_src_sel_i  : selects which pad_evt_i source can reload the counter;
//                    values >= NUM_PAD_SRC select nothing
//   pad_evt_i      : level event sources
//   pad_cnt_o      : current counter value (0 = padding satisfied)
//   ceil_o         : overrun measure, pad_i - pad_cnt_o, or 0 when counter is 0
// -----------------------------------------------------------------------------
module fence_t_pad_timer
   import uarch_rst_seq_pkg::*;
#(
   parameter  int unsigned NUM_PAD_SRC = 2,
   parameter  int unsigned PAD_W       = 32,
   localparam int unsigned SEL_W       = sel_width(NUM_PAD_SRC)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [PAD_W-1:0]       pad_i,
   input  logic [SEL_W-1:0]       pad_src_sel_i,
   input  logic [NUM_PAD_SRC-1:0] pad_evt_i,
   output logic [PAD_W-1:0]       pad_cnt_o,
   output logic [PAD_W-1:0]       ceil_o
);

   logic [NUM_PAD_SRC-1:0] evt_q;
   logic [NUM_PAD_SRC-1:0] rise;
   logic                   load;
   logic [PAD_W-1:0]       cnt_q;
   logic [PAD_W-1:0]       cnt_d;

   // Every source keeps its own history, so moving the select onto a source
   // that is already high does not look like an edge.
   assign rise = pad_evt_i & ~evt_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      load = 1'b0;
      for (int i = 0; i < NUM_PAD_SRC; i++) begin
         if (pad_src_sel_i == SEL_W'(i) && rise[i]) begin
            load = 1'b1;
         end
      end
   end

   // Load has priority over the decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = pad_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - PAD_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!rst_ni) begin
         evt_q <= '0;
         cnt_q <= '0;
      end else begin
         evt_q <= pad_evt_i;
         cnt_q <= cnt_d;
      end
   end

   assign pad_cnt_o = cnt_q;
   assign ceil_o    = (cnt_q == '0) ? '0 : pad_i - cnt_q;

endmodule

// File: rtl/uarch_rst_seq.sv
// -----------------------------------------------------------------------------
// uarch_rst_seq
// fence.t micro-reset sequencer: flush all channels, wait for a quiet drain
// window, pad to the selected timing event, then pulse a microarchitectural
// reset and resume at the instruction after the fence.t.
//   clk_i, rst_ni    : clock, async active-low reset
//   boot_addr_i      : rst_addr_o value until the first fence.t
//   pc_commit_i      : PC of the committing fence.t
//   fence_t_i        : fence.t commit pulse (only honoured in IDLE)
//   flush_if         : per-channel flush req/ack and busy flags
//   pad_i            : pad reload value
//   pad_src_sel_i    : selected pad event source
//   pad_evt_i        : pad event sources (level)
//   fence_t_ceil_o   : pad overrun measure, updated when DRAIN ends
//   ceil_valid_o     : one-cycle strobe, fence_t_ceil_o updated
//   halt_o, stall_o  : high whenever the sequencer is not IDLE
//   rst_uarch_no     : active-low microarchitectural reset (low in RST)
//   cache_init_no    : high in RST and INIT_HOLD cycles after it
//   rst_addr_o       : resume address after reset
// -----------------------------------------------------------------------------
module uarch_rst_seq
   import uarch_rst_seq_pkg::*;
#(
   parameter  int unsigned NUM_FLUSH    = 2,
   parameter  int unsigned DRAIN_CYCLES = 15,
   parameter  int unsigned RST_CYCLES   = 16,
   parameter  int unsigned INIT_HOLD    = 3,
   parameter  int unsigned NUM_PAD_SRC  = 2,
   parameter  int unsigned PAD_W        = 32,
   parameter  int unsigned VLEN         = 64,
   localparam int unsigned SEL_W        = sel_width(NUM_PAD_SRC)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [VLEN-1:0]        boot_addr_i,
   input  logic [VLEN-1:0]        pc_commit_i,
   input  logic                   fence_t_i,
   uarch_rst_seq_if.master        flush_if,
   input  logic [PAD_W-1:0]       pad_i,
   input  logic [SEL_W-1:0]       pad_src_sel_i,
   input  logic [NUM_PAD_SRC-1:0] pad_evt_i,
   output logic [PAD_W-1:0]       fence_t_ceil_o,
   output logic                   ceil_valid_o,
   output logic                   halt_o,
   output logic                   stall_o,
   output logic                   rst_uarch_no,
   output logic                   cache_init_no,
   output logic [VLEN-1:0]        rst_addr_o
);

   localparam fence_t_cfg_t CFG = '{
      num_flush:    NUM_FLUSH,
      drain_cycles: DRAIN_CYCLES,
      rst_cycles:   RST_CYCLES,
      init_hold:    INIT_HOLD,
      num_pad_src:  NUM_PAD_SRC,
      pad_w:        PAD_W,
      vlen:         VLEN
   };

   localparam int unsigned DRAIN_W = cnt_width(CFG.drain_cycles);
   localparam int unsigned RST_W   = cnt_width(CFG.rst_cycles);
   localparam int unsigned HOLD_W  = cnt_width(CFG.init_hold);

   localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(CFG.drain_cycles);
   localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(CFG.rst_cycles - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(CFG.init_hold);

   fence_t_state_e       state_q;
   logic [NUM_FLUSH-1:0] flush_req_q;
   logic [NUM_FLUSH-1:0] pending_nxt;
   logic [DRAIN_W-1:0]   drain_cnt_q;
   logic [RST_W-1:0]     rst_cnt_q;
   logic [HOLD_W-1:0]    hold_cnt_q;
   logic [PAD_W-1:0]     ceil_q;
   logic                 ceil_valid_q;
   logic [VLEN-1:0]      addr_q;
   logic                 addr_set_q;
   logic [PAD_W-1:0]     pad_cnt;
   logic [PAD_W-1:0]     pad_ceil;

   fence_t_pad_timer #(
      .NUM_PAD_SRC (NUM_PAD_SRC),
      .PAD_W       (PAD_W)
   ) i_pad_timer (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .pad_i         (pad_i),
      .pad_src_sel_i (pad_src_sel_i),
      .pad_evt_i     (pad_evt_i),
      .pad_cnt_o     (pad_cnt),
      .ceil_o        (pad_ceil)
   );

   // Channels still waiting after this cycle's acks; acks on channels that
   // are already done fall out of the mask.
   assign pending_nxt = flush_req_q & ~flush_if.flush_ack;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= FT_IDLE;
         flush_req_q  <= '0;
         drain_cnt_q  <= '0;
         rst_cnt_q    <= '0;
         hold_cnt_q   <= '0;
         ceil_q       <= '0;
         ceil_valid_q <= 1'b0;
         addr_q       <= '0;
         addr_set_q   <= 1'b0;
      end else begin
         ceil_valid_q <= 1'b0;
         if (hold_cnt_q != '0) begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
         end

         unique case (state_q)
            FT_IDLE: begin
               if (fence_t_i) begin
                  state_q     <= FT_FLUSH;
                  flush_req_q <= '1;
                  addr_q      <= pc_commit_i + VLEN'(4);
                  addr_set_q  <= 1'b1;
               end
            end

            FT_FLUSH: begin
               flush_req_q <= pending_nxt;
               if (pending_nxt == '0) begin
                  state_q     <= FT_DRAIN;
                  drain_cnt_q <= '0;
               end
            end

            // Needs DRAIN_CYCLES consecutive quiet cycles after the last busy.
            FT_DRAIN: begin
               if (drain_cnt_q == DRAIN_MAX) begin
                  state_q      <= FT_PAD;
                  ceil_q       <= pad_ceil;
                  ceil_valid_q <= 1'b1;
               end else if (|flush_if.busy) begin
                  drain_cnt_q <= '0;
               end else begin
                  drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
               end
            end

            FT_PAD: begin
               if (pad_cnt == '0) begin
                  state_q <= FT_RST;
               end
            end

            FT_RST: begin
               if (rst_cnt_q == RST_LAST) begin
                  state_q    <= FT_IDLE;
                  rst_cnt_q  <= '0;
                  hold_cnt_q <= HOLD_LOAD;
               end else begin
                  rst_cnt_q <= rst_cnt_q + RST_W'(1);
               end
            end

            default: begin
               state_q <= FT_IDLE;
            end
         endcase
      end
   end

   assign flush_if.flush_req = flush_req_q;
   assign fence_t_ceil_o     = ceil_q;
   assign ceil_valid_o       = ceil_valid_q;
   assign halt_o             = (state_q != FT_IDLE);
   assign stall_o            = (state_q != FT_IDLE);
   assign rst_uarch_no       = (state_q != FT_RST);
   assign cache_init_no      = (state_q == FT_RST) || (hold_cnt_q != '0);

   // NOTE: the resume address register resets to a constant and a flag selects
   // boot_addr_i until the first fence.t, instead of async-loading a live input
   // into the flop; a reset mid-sequence still shows boot_addr_i at once.
   assign rst_addr_o = addr_set_q ? addr_q : boot_addr_i;

endmodule

// File: tb/tb_uarch_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_uarch_rst_seq
// Directed bench for uarch_rst_seq. Each test pushes its expected observable
// events (flush_req changes, ceil value, DRAIN/PAD/RST/cache_init lengths,
// resume address) into per-kind queues; an independent monitor measures the
// DUT outputs on the falling edge and pops/compares as events appear.
// -----------------------------------------------------------------------------
module tb_uarch_rst_seq;
   import uarch_rst_seq_pkg::*;

   localparam int unsigned NUM_FLUSH    = 2;
   localparam int unsigned DRAIN_CYCLES = 15;
   localparam int unsigned RST_CYCLES   = 16;
   localparam int unsigned INIT_HOLD    = 3;
   localparam int unsigned NUM_PAD_SRC  = 2;
   localparam int unsigned PAD_W        = 32;
   localparam int unsigned VLEN         = 64;
   localparam int unsigned SEL_W        = sel_width(NUM_PAD_SRC);
   localparam logic [VLEN-1:0] BOOT     = 64'h0000_0000_0001_0000;

   logic                   clk_i = 1'b0;
   logic                   rst_ni = 1'b0;
   logic [VLEN-1:0]        boot_addr_i;
   logic [VLEN-1:0]        pc_commit_i;
   logic                   fence_t_i;
   logic [PAD_W-1:0]       pad_i;
   logic [SEL_W-1:0]       pad_src_sel_i;
   logic [NUM_PAD_SRC-1:0] pad_evt_i;
   logic [PAD_W-1:0]       fence_t_ceil_o;
   logic                   ceil_valid_o;
   logic                   halt_o;
   logic                   stall_o;
   logic                   rst_uarch_no;
   logic                   cache_init_no;
   logic [VLEN-1:0]        rst_addr_o;

   uarch_rst_seq_if #(.NUM_FLUSH(NUM_FLUSH)) flush_if ();

   uarch_rst_seq #(
      .NUM_FLUSH    (NUM_FLUSH),
      .DRAIN_CYCLES (DRAIN_CYCLES),
      .RST_CYCLES   (RST_CYCLES),
      .INIT_HOLD    (INIT_HOLD),
      .NUM_PAD_SRC  (NUM_PAD_SRC),
      .PAD_W        (PAD_W),
      .VLEN         (VLEN)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .boot_addr_i    (boot_addr_i),
      .pc_commit_i    (pc_commit_i),
      .fence_t_i      (fence_t_i),
      .flush_if       (flush_if),
      .pad_i          (pad_i),
      .pad_src_sel_i  (pad_src_sel_i),
      .pad_evt_i      (pad_evt_i),
      .fence_t_ceil_o (fence_t_ceil_o),
      .ceil_valid_o   (ceil_valid_o),
      .halt_o         (halt_o),
      .stall_o        (stall_o),
      .rst_uarch_no   (rst_uarch_no),
      .cache_init_no  (cache_init_no),
      .rst_addr_o     (rst_addr_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_err    = 0;

   logic [63:0] q_req[$];
   logic [63:0] q_ceil[$];
   logic [63:0] q_drain[$];
   logic [63:0] q_pad[$];
   logic [63:0] q_rst[$];
   logic [63:0] q_init[$];
   logic [63:0] q_addr[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      n_checks++;
      n_err++;
      $display("FAIL %s: got 0x%0h with no expected entry queued", name, act);
   endtask

   // ---------------------------------------------------------------- monitor
   initial begin : monitor
      logic [NUM_FLUSH-1:0] req_prev;
      int  drain_n, pad_n, rst_n, init_n;
      bit  in_drain, in_pad;
      req_prev = '0;
      drain_n  = 0; pad_n = 0; rst_n = 0; init_n = 0;
      in_drain = 1'b0; in_pad = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            req_prev = '0;
            drain_n  = 0; pad_n = 0; rst_n = 0; init_n = 0;
            in_drain = 1'b0; in_pad = 1'b0;
         end else begin
            if (flush_if.flush_req !== req_prev) begin
               if (q_req.size() != 0) check("flush_req", 64'(flush_if.flush_req), q_req.pop_front());
               else unexpected("flush_req", 64'(flush_if.flush_req));
               if (flush_if.flush_req == '0 && halt_o) begin
                  in_drain = 1'b1;
                  drain_n  = 0;
               end
               req_prev = flush_if.flush_req;
            end
            if (in_drain) begin
               if (ceil_valid_o) begin
                  if (q_drain.size() != 0) check("drain_len", 64'(drain_n), q_drain.pop_front());
                  else unexpected("drain_len", 64'(drain_n));
                  in_drain = 1'b0;
               end else begin
                  drain_n++;
               end
            end
            if (ceil_valid_o) begin
               if (q_ceil.size() != 0) check("ceil", 64'(fence_t_ceil_o), q_ceil.pop_front());
               else unexpected("ceil", 64'(fence_t_ceil_o));
               in_pad = 1'b1;
               pad_n  = 0;
            end
            if (in_pad) begin
               if (!rst_uarch_no) begin
                  if (q_pad.size() != 0) check("pad_len", 64'(pad_n), q_pad.pop_front());
                  else unexpected("pad_len", 64'(pad_n));
                  in_pad = 1'b0;
               end else begin
                  pad_n++;
               end
            end
            if (!rst_uarch_no) begin
               rst_n++;
            end else if (rst_n != 0) begin
               if (q_rst.size() != 0) check("rst_len", 64'(rst_n), q_rst.pop_front());
               else unexpected("rst_len", 64'(rst_n));
               if (q_addr.size() != 0) check("rst_addr", rst_addr_o, q_addr.pop_front());
               else unexpected("rst_addr", rst_addr_o);
               rst_n = 0;
            end
            if (cache_init_no) begin
               init_n++;
            end else if (init_n != 0) begin
               if (q_init.size() != 0) check("init_len", 64'(init_n), q_init.pop_front());
               else unexpected("init_len", 64'(init_n));
               init_n = 0;
            end
         end
      end
   end

   // -------------------------------------------------------------- stimulus
   typedef struct {
      logic [VLEN-1:0] pc;
      int ack0_at;
      int ack1_at;
      int busy_at;
      int evt_src;
      int evt_at;
      int sel_at;
      int sel_new;
      int fence2_at;
      int abort_at;
   } seq_t;

   function automatic seq_t seq_default(input logic [VLEN-1:0] pc);
      seq_t s;
      s.pc = pc; s.ack0_at = 1; s.ack1_at = 1; s.busy_at = 0;
      s.evt_src = 0; s.evt_at = 0; s.sel_at = 0; s.sel_new = 0;
      s.fence2_at = 0; s.abort_at = 0;
      return s;
   endfunction

   task automatic push_head(input logic [63:0] ceil, input logic [63:0] drain, input logic [63:0] pad);
      q_ceil.push_back(ceil);
      q_drain.push_back(drain);
      q_pad.push_back(pad);
   endtask

   task automatic push_tail(input logic [63:0] addr);
      q_rst.push_back(64'd16);
      q_init.push_back(64'd19);
      q_addr.push_back(addr);
   endtask

   // Edge numbering: E0 samples fence_t_i; loop iteration c sets the inputs
   // that edge Ec samples.
   task automatic run_seq(input seq_t s);
      int last;
      bit done;
      last = s.ack0_at;
      if (s.ack1_at   > last) last = s.ack1_at;
      if (s.busy_at   > last) last = s.busy_at;
      if (s.evt_at    > last) last = s.evt_at;
      if (s.sel_at    > last) last = s.sel_at;
      if (s.fence2_at > last) last = s.fence2_at;
      done = 1'b0;
      fence_t_i   = 1'b1;
      pc_commit_i = s.pc;
      @(posedge clk_i); #1;
      fence_t_i   = 1'b0;
      pc_commit_i = 64'h5555_5555_5555_5550;
      for (int c = 1; c <= 400; c++) begin
         if (c == s.ack0_at) flush_if.flush_ack[0] = 1'b1;
         if (c == s.ack1_at) flush_if.flush_ack[1] = 1'b1;
         if (c == s.busy_at) flush_if.busy[1] = 1'b1;
         if (c == s.evt_at)  pad_evt_i = pad_evt_i | (NUM_PAD_SRC'(1) << s.evt_src);
         if (c == s.sel_at)  pad_src_sel_i = SEL_W'(s.sel_new);
         if (c == s.fence2_at) begin
            fence_t_i   = 1'b1;
            pc_commit_i = 64'h0000_0000_0000_1234;
         end
         @(posedge clk_i); #1;
         flush_if.flush_ack = '0;
         flush_if.busy      = '0;
         fence_t_i          = 1'b0;
         if (c == s.abort_at) begin
            check("rst_low_before_abort", 64'(rst_uarch_no), 64'd0);
            check("halt_before_abort", 64'(halt_o), 64'd1);
            #2 rst_ni = 1'b0;
            #1;
            check("abort_rst_uarch_no", 64'(rst_uarch_no), 64'd1);
            check("abort_halt", 64'(halt_o), 64'd0);
            check("abort_stall", 64'(stall_o), 64'd0);
            check("abort_cache_init", 64'(cache_init_no), 64'd0);
            check("abort_rst_addr", rst_addr_o, BOOT);
            @(posedge clk_i); @(posedge clk_i); #1;
            rst_ni = 1'b1;
            done = 1'b1;
            break;
         end
         if (c >= last && !halt_o && !cache_init_no) begin
            done = 1'b1;
            break;
         end
      end
      pad_evt_i = '0;
      check("seq_done", 64'(done), 64'd1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: no finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      seq_t s;
      boot_addr_i        = BOOT;
      pc_commit_i        = '0;
      fence_t_i          = 1'b0;
      pad_i              = '0;
      pad_src_sel_i      = '0;
      pad_evt_i          = '0;
      flush_if.flush_ack = '0;
      flush_if.busy      = '0;

      // Reset state
      @(posedge clk_i); @(posedge clk_i); #1;
      check("rst_flush_req", 64'(flush_if.flush_req), 64'd0);
      check("rst_ceil", 64'(fence_t_ceil_o), 64'd0);
      check("rst_ceil_valid", 64'(ceil_valid_o), 64'd0);
      check("rst_halt", 64'(halt_o), 64'd0);
      check("rst_stall", 64'(stall_o), 64'd0);
      check("rst_uarch_no", 64'(rst_uarch_no), 64'd1);
      check("rst_cache_init", 64'(cache_init_no), 64'd0);
      check("rst_addr", rst_addr_o, BOOT);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // 1: basic, acks at +2 and +5, no padding
      s = seq_default(64'h0000_0000_8000_1000);
      s.ack0_at = 2; s.ack1_at = 5;
      q_req.push_back(64'h3); q_req.push_back(64'h2); q_req.push_back(64'h0);
      push_head(64'd0, 64'd16, 64'd1);
      push_tail(64'h0000_0000_8000_1004);
      run_seq(s);

      // 2: simultaneous acks, busy at DRAIN cycle 10 -> 10+1+16 DRAIN cycles
      s = seq_default(64'h0000_0000_0000_2000);
      s.busy_at = 12;
      q_req.push_back(64'h3); q_req.push_back(64'h0);
      push_head(64'd0, 64'd27, 64'd1);
      push_tail(64'h0000_0000_0000_2004);
      run_seq(s);

      // 3: padding: load 100 at E5, DRAIN ends at E46 with 60 left -> ceil 40,
      //    PAD 60 cycles; fence.t during PAD ignored
      pad_i = 32'd100;
      pad_src_sel_i = '0;
      s = seq_default(64'h0000_0000_4000_0000);
      s.ack0_at = 30; s.ack1_at = 30;
      s.evt_src = 0; s.evt_at = 5; s.fence2_at = 60;
      q_req.push_back(64'h3); q_req.push_back(64'h0);
      push_head(64'd40, 64'd16, 64'd60);
      push_tail(64'h0000_0000_4000_0004);
      run_seq(s);

      // 4: no event -> ceil 0, PAD 1 cycle; PC wraps
      s = seq_default(64'hFFFF_FFFF_FFFF_FFFF);
      q_req.push_back(64'h3); q_req.push_back(64'h0);
      push_head(64'd0, 64'd16, 64'd1);
      push_tail(64'h0000_0000_0000_0003);
      run_seq(s);

      // 5: select 1, edge on source 0 -> no load
      pad_src_sel_i = SEL_W'(1);
      s = seq_default(64'h0000_0000_0000_3000);
      s.evt_src = 0; s.evt_at = 5;
      q_req.push_back(64'h3); q_req.push_back(64'h0);
      push_head(64'd0, 64'd16, 64'd1);
      push_tail(64'h0000_0000_0000_3004);
      run_seq(s);

      // 6: select 1, edge on source 1 at E5 -> 89 left at E17, ceil 11, PAD 89
      pad_src_sel_i = SEL_W'(1);
      s = seq_default(64'h0000_0000_0000_4000);
      s.evt_src = 1; s.evt_at = 5;
      q_req.push_back(64'h3); q_req.push_back(64'h0);
      push_head(64'd11, 64'd16, 64'd89);
      push_tail(64'h0000_0000_0000_4004);
      run_seq(s);

      // 7: source 1 rises while select is 0, select moves to 1 later -> no load
      pad_src_sel_i = '0;
      s = seq_default(64'h0000_0000_0000_5000);
      s.evt_src = 1; s.evt_at = 2; s.sel_at = 5; s.sel_new = 1;
      q_req.push_back(64'h3); q_req.push_back(64'h0);
      push_head(64'd0, 64'd16, 64'd1);
      push_tail(64'h0000_0000_0000_5004);
      run_seq(s);

      // 8: reset asserted in RST (RST spans after E18..E33)
      pad_src_sel_i = '0;
      s = seq_default(64'h0000_0000_0000_6000);
      s.abort_at = 25;
      q_req.push_back(64'h3); q_req.push_back(64'h0);
      push_head(64'd0, 64'd16, 64'd1);
      run_seq(s);

      repeat (3) @(posedge clk_i);
      #1;
      check("post_abort_flush_req", 64'(flush_if.flush_req), 64'd0);
      check("post_abort_rst_addr", rst_addr_o, BOOT);
      check("left_req", 64'(q_req.size()), 64'd0);
      check("left_ceil", 64'(q_ceil.size()), 64'd0);
      check("left_drain", 64'(q_drain.size()), 64'd0);
      check("left_pad", 64'(q_pad.size()), 64'd0);
      check("left_rst", 64'(q_rst.size()), 64'd0);
      check("left_init", 64'(q_init.size()), 64'd0);
      check("left_addr", 64'(q_addr.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
